// File: rtl/fifo_ctl_if.sv
// Handshake and status bundle between a FIFO user (master) and fifo_ctl (slave).
interface fifo_ctl_if #(
    parameter int BITS_DEPTH = 8,
    parameter int BITS_WIDTH = 32
);
    logic [BITS_WIDTH-1:0] din;
    logic                  wr_en;
    logic                  rd_en;
    logic [BITS_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [BITS_DEPTH:0]   level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output din, wr_en, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctl.sv
// Single-clock FIFO controller with standard or first-word-fall-through read,
// full-range level, runtime almost thresholds, flush and sticky error flags.
// In FWFT mode the head word lives in the output register and the memory holds
// the remaining level-1 words, so capacity stays 2**BITS_DEPTH in both modes.
module fifo_ctl #(
    parameter int BITS_DEPTH = 8,
    parameter int BITS_WIDTH = 32,
    parameter int FWFT       = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic                i_clr_err,
    input  logic [BITS_DEPTH:0] af_thresh,
    input  logic [BITS_DEPTH:0] ae_thresh,
    fifo_ctl_if.slave           bus
);
    localparam int                DEPTH     = 2 ** BITS_DEPTH;
    localparam bit                FWFT_MODE = (FWFT != 0);
    localparam logic [BITS_DEPTH:0] LV_ZERO = {(BITS_DEPTH+1){1'b0}};
    localparam logic [BITS_DEPTH:0] LV_ONE  = {{BITS_DEPTH{1'b0}}, 1'b1};
    localparam logic [BITS_DEPTH:0] LV_FULL = (BITS_DEPTH+1)'(DEPTH);

    logic [BITS_WIDTH-1:0] mem_r [DEPTH];
    logic [BITS_DEPTH:0]   wr_ptr_r;
    logic [BITS_DEPTH:0]   rd_ptr_r;
    logic [BITS_DEPTH:0]   level_r;
    logic [BITS_WIDTH-1:0] dout_r;
    logic                  dout_valid_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  mem_we_s;
    logic                  mem_pop_s;
    logic                  load_mem_s;
    logic                  load_din_s;
    logic                  valid_nxt_s;
    logic                  ovf_set_s;
    logic                  unf_set_s;
    logic [BITS_DEPTH:0]   mem_cnt_s;
    logic [BITS_DEPTH:0]   level_nxt_s;

    // Status flags come from the registered level only.
    assign full_s  = (level_r == LV_FULL);
    assign empty_s = (level_r == LV_ZERO);

    // Acceptance, memory/output-register steering and next level.
    always_comb begin
        wr_acc_s    = bus.wr_en && !full_s;
        rd_acc_s    = bus.rd_en && !empty_s;
        ovf_set_s   = !i_flush && bus.wr_en && full_s;
        unf_set_s   = !i_flush && bus.rd_en && empty_s;
        mem_cnt_s   = wr_ptr_r - rd_ptr_r;
        mem_we_s    = 1'b0;
        mem_pop_s   = 1'b0;
        load_mem_s  = 1'b0;
        load_din_s  = 1'b0;
        valid_nxt_s = 1'b0;
        if (FWFT_MODE) begin
            if (!dout_valid_r) begin
                // Empty: a write goes straight into the output register.
                load_din_s  = wr_acc_s;
                valid_nxt_s = wr_acc_s;
            end else if (rd_acc_s) begin
                if (mem_cnt_s != LV_ZERO) begin
                    load_mem_s  = 1'b1;
                    mem_pop_s   = 1'b1;
                    mem_we_s    = wr_acc_s;
                    valid_nxt_s = 1'b1;
                end else begin
                    // Last word popped: a concurrent write becomes the head.
                    load_din_s  = wr_acc_s;
                    valid_nxt_s = wr_acc_s;
                end
            end else begin
                mem_we_s    = wr_acc_s;
                valid_nxt_s = 1'b1;
            end
        end else begin
            mem_we_s    = wr_acc_s;
            mem_pop_s   = rd_acc_s;
            load_mem_s  = rd_acc_s;
            valid_nxt_s = rd_acc_s;
        end
        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_nxt_s = level_r + LV_ONE;
            2'b01:   level_nxt_s = level_r - LV_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Storage array; writes are dropped in reset and flush cycles.
    always_ff @(posedge i_clk) begin
        if (mem_we_s && !i_rst && !i_flush) begin
            mem_r[wr_ptr_r[BITS_DEPTH-1:0]] <= bus.din;
        end
    end

    // Pointers, level and output register; reset and flush clear contents alike.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr_r     <= LV_ZERO;
            rd_ptr_r     <= LV_ZERO;
            level_r      <= LV_ZERO;
            dout_r       <= {BITS_WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
        end else begin
            if (mem_we_s) begin
                wr_ptr_r <= wr_ptr_r + LV_ONE;
            end
            if (mem_pop_s) begin
                rd_ptr_r <= rd_ptr_r + LV_ONE;
            end
            if (load_mem_s) begin
                dout_r <= mem_r[rd_ptr_r[BITS_DEPTH-1:0]];
            end else if (load_din_s) begin
                dout_r <= bus.din;
            end
            level_r      <= level_nxt_s;
            dout_valid_r <= valid_nxt_s;
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= ovf_set_s || (overflow_r && !i_clr_err);
            underflow_r <= unf_set_s || (underflow_r && !i_clr_err);
        end
    end

    assign bus.dout         = dout_r;
    assign bus.dout_valid   = dout_valid_r;
    assign bus.full         = full_s;
    assign bus.empty        = empty_s;
    assign bus.almost_full  = (level_r >= af_thresh);
    assign bus.almost_empty = (level_r <= ae_thresh);
    assign bus.level        = level_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;
endmodule

// File: doc/fifo_ctl.md
Name: fifo_ctl

Overview:
- Parametrised synchronous single-clock FIFO; next-generation buffer for DMA/AXI-PCIe datapaths.
- Adds the following over the basic FIFO:
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - full-range occupancy count;
  - runtime almost-full/almost-empty thresholds;
  - flush;
  - sticky overflow/underflow error flags.
- Capacity is exactly 2**BITS_DEPTH words in both modes.

Parameters:
- BITS_DEPTH, 8, log2 of capacity; DEPTH = 2**BITS_DEPTH; legal 2..12.
- BITS_WIDTH, 32, data word width.
- FWFT, 0, 0 = standard read (data one cycle after rd_en); 1 = head word presented on dout with dout_valid.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_flush  in  1  synchronous clear of contents (not error flags).
- i_clr_err  in  1  clears overflow/underflow.
- din  in  BITS_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request (pop in FWFT).
- af_thresh  in  BITS_DEPTH+1  almost-full threshold.
- ae_thresh  in  BITS_DEPTH+1  almost-empty threshold.
- dout  out  BITS_WIDTH  read data, registered.
- dout_valid  out  1  dout holds a valid word (see Behaviour).
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= af_thresh.
- almost_empty  out  1  level <= ae_thresh.
- level  out  BITS_DEPTH+1  words held, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset: i_rst synchronous, active-high, highest priority.
  - Clears pointers, level, dout=0, dout_valid=0, overflow=0, underflow=0.
  - Resulting outputs: empty=1, full=0, almost_empty=1 (for ae_thresh>=0), almost_full=(af_thresh==0).
  - Reset mid-transfer discards all content.
- Flush: i_flush has priority over wr_en/rd_en.
  - Same clearing as reset except overflow/underflow are retained.
  - wr_en/rd_en in the flush cycle are dropped and never flag errors.
- Acceptance, evaluated on pre-edge state:
  - wr_acc = wr_en && !full.
  - rd_acc = rd_en && !empty.
  - A write while full is rejected even with a concurrent accepted read (no pass-through when full).
- Level update: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither. Never wraps.
- Pointers: BITS_DEPTH+1 bits; wrap modulo 2*DEPTH; memory indexed by the low BITS_DEPTH bits.
- Errors:
  - overflow <= 1 on wr_en && full.
  - underflow <= 1 on rd_en && empty.
  - i_clr_err clears both; a same-cycle new error wins, i.e. the flag stays 1.
- Standard mode (FWFT=0):
  - rd_acc loads dout with the head word at that edge; dout_valid=1 for exactly the following cycle.
  - Otherwise dout holds its value and dout_valid=0.
  - Read of an empty FIFO with concurrent write: read rejected (underflow set), write accepted, no bypass.
- FWFT mode (FWFT=1):
  - dout_valid = !empty; dout is the head word whenever dout_valid=1.
  - Write into empty FIFO: dout/dout_valid update at the write edge, so the word is visible the next cycle (latency 1).
  - rd_acc pops; the next word (or a same-cycle write if it would become the head) appears the following cycle.
  - Level counts the presented word.
  - Implementation uses an output register plus memory; the memory never holds more than DEPTH-1 words while the output register is valid.
- Flags: full, empty, almost_*, and level are derived only from registered level; no combinational path from wr_en/rd_en.
- Thresholds: may change any cycle and take effect immediately on the comparisons.
  - af_thresh=0 forces almost_full=1.
  - ae_thresh>=DEPTH forces almost_empty=1.

Test Plan (BITS_DEPTH=3, BITS_WIDTH=16, af_thresh=6, ae_thresh=1):
- FWFT=0: write 0x0001..0x0008 back-to-back.
  - level reaches 8, full=1; almost_full=1 from level 6; almost_empty=0 from level 2.
  - 9th write 0x0009 -> level stays 8, overflow=1.
  - 8 reads -> dout = 0x0001..0x0008 each one cycle after rd_en with dout_valid pulsed; empty=1.
- FWFT=1: single write 0xABCD into empty.
  - Next cycle dout=0xABCD, dout_valid=1, level=1.
  - rd_en for one cycle -> dout_valid=0, empty=1.
  - Extra rd_en -> underflow=1.
- Simultaneous:
  - rd_en+wr_en at level 4 -> level stays 4, data order preserved.
  - At level 8 -> read accepted, write dropped, overflow=1, level=7.
  - At level 0 (FWFT=0) -> underflow=1, level=1.
- Wrap-around: 20 interleaved write/read pairs with random levels 0..8 -> dout sequence matches a scoreboard; level never exceeds 8.
- Flush at level 5 with concurrent wr_en -> next cycle level=0, empty=1, dout_valid=0, no error set; a previously set overflow remains 1 until i_clr_err.
- i_rst asserted mid-burst (level 3, rd_en high) -> next cycle all outputs at reset values; the following write of 0x1234 is the first word read back.
